// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg: shared state encoding, default parameters and width helpers for the PE array sequencer
package pe_sched_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    localparam int DEF_PE_NUM     = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LOAD_NUM   = 64;
    localparam int DEF_RUN_CYCLES = 1024;
    localparam int DEF_WORD_W     = 2 * DEF_DATA_WIDTH;
    function automatic int word_w(input int dw);
        return 2 * dw;
    endfunction
    // index width able to address n entries, never below one bit
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pe_array_sched_bank.sv
// pe_result_bank: capture-once result registers for every PE with an all-captured flag and a read mux
//   clk, rst          : clock, synchronous active-high reset (clears flags and results)
//   clear             : drop all capture flags, results kept
//   cap_en            : capture window; pe_out_v is ignored while low
//   zero_fill         : mark every uncaptured PE as captured with a zero result
//   pe_out_v, pe_out  : per-PE valid and flattened PE results
//   rd_idx, rdata     : read index and selected result
//   all_cap           : every PE has been captured
module pe_result_bank
    import pe_sched_pkg::*;
#(
    parameter int PE_NUM = DEF_PE_NUM,
    parameter int W      = DEF_WORD_W,
    parameter int AW     = idx_w(DEF_PE_NUM)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                cap_en,
    input  logic                zero_fill,
    input  logic [PE_NUM-1:0]   pe_out_v,
    input  logic [PE_NUM*W-1:0] pe_out,
    input  logic [AW-1:0]       rd_idx,
    output logic                all_cap,
    output logic [W-1:0]        rdata
);
    logic [PE_NUM-1:0] cap;
    logic [W-1:0]      res [PE_NUM];

    assign all_cap = &cap;
    assign rdata   = res[rd_idx];

    // a live capture wins over zero fill so a result arriving on the watchdog edge is kept
    always_ff @(posedge clk)
        for (int k = 0; k < PE_NUM; k++)
            if (rst) begin
                cap[k] <= 1'b0;
                res[k] <= '0;
            end else if (clear)
                cap[k] <= 1'b0;
            else if (!cap[k] && cap_en && pe_out_v[k]) begin
                cap[k] <= 1'b1;
                res[k] <= pe_out[k*W +: W];
            end else if (!cap[k] && zero_fill) begin
                cap[k] <= 1'b1;
                res[k] <= '0;
            end
endmodule

// File: rtl/pe_array_sched.sv
// pe_array_sched: job sequencer that loads the PE array word by word, collects one result per PE and serialises them
//   clk, rst                      : clock, synchronous active-high reset
//   start                         : job start pulse, honoured only when idle
//   din_overlay_v/din_overlay     : input word stream, accepted while din_ready
//   pe_in_v/pe_in                 : one-hot load strobe and broadcast data, one cycle after acceptance
//   pe_out_v/pe_out               : per-PE result valid and flattened results
//   dout_overlay_v/dout_overlay   : serialised results, PE 0 first, held under dout_ready backpressure
//   busy, done, err               : not idle, one-cycle job end, sticky watchdog flag
//   Macro PE_ARRAY_SCHED_TIMEOUT_EN enables the RUN watchdog (RUN_CYCLES); without it err is constant 0.
module pe_array_sched
    import pe_sched_pkg::*;
#(
    parameter int PE_NUM     = DEF_PE_NUM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LOAD_NUM   = DEF_LOAD_NUM,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             din_overlay_v,
    input  logic [2*DATA_WIDTH-1:0]          din_overlay,
    output logic                             din_ready,
    output logic [PE_NUM-1:0]                pe_in_v,
    output logic [2*DATA_WIDTH-1:0]          pe_in,
    input  logic [PE_NUM-1:0]                pe_out_v,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]   pe_out,
    output logic                             dout_overlay_v,
    output logic [2*DATA_WIDTH-1:0]          dout_overlay,
    input  logic                             dout_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);
    localparam int W   = word_w(DATA_WIDTH);
    localparam int WCW = $clog2(LOAD_NUM) + 1;
    localparam int PCW = $clog2(PE_NUM) + 1;
    localparam int AW  = idx_w(PE_NUM);
    localparam logic [WCW-1:0] W_LAST = WCW'(LOAD_NUM - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(PE_NUM - 1);

    state_t         state, state_nx;
    logic [WCW-1:0] wcnt;
    logic [PCW-1:0] pe_sel, rd_idx;
    logic           accept, all_cap, timeout;
    logic [W-1:0]   rdata;

    assign accept         = state == LOAD && din_overlay_v;
    assign din_ready      = state == LOAD;
    assign busy           = state != IDLE;
    assign done           = state == DONE;
    assign dout_overlay_v = state == DRAIN;
    assign dout_overlay   = state == DRAIN ? rdata : '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (accept && wcnt == W_LAST && pe_sel == P_LAST) state_nx = RUN;
            RUN:     if (all_cap || timeout) state_nx = DRAIN;
            DRAIN:   if (dout_ready && rd_idx == P_LAST) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            pe_sel  <= '0;
            rd_idx  <= '0;
            pe_in_v <= '0;
            pe_in   <= '0;
        end else begin
            state   <= state_nx;
            pe_in_v <= accept ? PE_NUM'(1) << pe_sel : '0;
            pe_in   <= accept ? din_overlay : '0;
            if (state == IDLE && start) begin
                wcnt   <= '0;
                pe_sel <= '0;
            end else if (accept) begin
                wcnt <= wcnt == W_LAST ? '0 : wcnt + 1'b1;
                if (wcnt == W_LAST) pe_sel <= pe_sel + 1'b1;
            end
            rd_idx <= state != DRAIN ? '0 : dout_ready ? rd_idx + 1'b1 : rd_idx;
        end

`ifdef PE_ARRAY_SCHED_TIMEOUT_EN
    localparam int RCW = $clog2(RUN_CYCLES) + 1;
    localparam logic [RCW-1:0] R_LAST = RCW'(RUN_CYCLES - 1);
    logic [RCW-1:0] rcnt;
    logic           err_q;
    // rcnt holds at zero outside RUN so every RUN visit starts counting from 0
    assign timeout = state == RUN && !all_cap && rcnt == R_LAST;
    assign err     = err_q;
    always_ff @(posedge clk)
        if (rst) begin
            rcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            rcnt  <= state == RUN ? rcnt + 1'b1 : '0;
            err_q <= timeout ? 1'b1 : (state == IDLE && start) ? 1'b0 : err_q;
        end
`else
    assign timeout = 1'b0;
    // always false; keeps RUN_CYCLES referenced in the watchdog-free build
    assign err     = RUN_CYCLES < 0;
`endif

    pe_result_bank #(.PE_NUM(PE_NUM), .W(W), .AW(AW)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == DONE),
        .cap_en    (state == RUN),
        .zero_fill (timeout),
        .pe_out_v  (pe_out_v),
        .pe_out    (pe_out),
        .rd_idx    (rd_idx[AW-1:0]),
        .all_cap   (all_cap),
        .rdata     (rdata)
    );
endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: randomized self-checking bench for pe_array_sched against a job-level reference model
module tb_pe_array_sched;
    localparam int PE_NUM = 4, DATA_WIDTH = 16, LOAD_NUM = 2, RUN_CYCLES = 16;
    localparam int W = 2 * DATA_WIDTH, TOT = PE_NUM * LOAD_NUM;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, din_overlay_v = 1'b0, dout_ready = 1'b0;
    logic [W-1:0] din_overlay = '0;
    logic [PE_NUM-1:0] pe_out_v = '0;
    logic [PE_NUM*W-1:0] pe_out = '0;
    logic din_ready, dout_overlay_v, busy, done, err;
    logic [PE_NUM-1:0] pe_in_v;
    logic [W-1:0] pe_in, dout_overlay;

    int checks = 0, failures = 0;
    logic [PE_NUM-1:0] mask_q[$];
    logic [W-1:0] exp_res[PE_NUM];

    always #5 clk = ~clk;

    pe_array_sched #(.PE_NUM(PE_NUM), .DATA_WIDTH(DATA_WIDTH), .LOAD_NUM(LOAD_NUM), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start),
        .din_overlay_v(din_overlay_v), .din_overlay(din_overlay), .din_ready(din_ready),
        .pe_in_v(pe_in_v), .pe_in(pe_in), .pe_out_v(pe_out_v), .pe_out(pe_out),
        .dout_overlay_v(dout_overlay_v), .dout_overlay(dout_overlay), .dout_ready(dout_ready),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({din_ready, pe_in_v, dout_overlay_v, busy, done, err}), 64'(0));
        check({tag, "_pe_in"}, 64'(pe_in), 64'(0));
        check({tag, "_dout"}, 64'(dout_overlay), 64'(0));
    endtask

    // gap: 0 none, 1 alternate, 2 random; hold: result index stalled 5 cycles (-1 none);
    // abort: reset after this many results (-1 none); expect_to: watchdog must fire
    task automatic run_job(input int gap, input bit nominal, input int hold, input bit rand_bp,
                           input bit glitch, input bit noise, input int abort, input bit expect_to);
        int n = 0, cyc = 0, i = 0, held = 0, used = 0, nm;
        logic [PE_NUM-1:0] cap = '0, m;
        logic [W-1:0] w, d;
        check("idle_busy", 64'(busy), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_busy", 64'(busy), 64'(1));
        check("start_clears_err", 64'(err), 64'(0));
        while (n < TOT && cyc < 200) begin
            din_overlay_v = gap == 0 ? 1'b1 : gap == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            w = nominal ? W'(n + 1) : W'($urandom);
            din_overlay = w;
            start = glitch && cyc == 3;
            pe_out_v = noise ? PE_NUM'($urandom) : '0;
            check("din_ready", 64'(din_ready), 64'(1));
            tick();
            if (din_overlay_v) begin
                check("pe_in_v", 64'(pe_in_v), 64'(1 << (n / LOAD_NUM)));
                check("pe_in", 64'(pe_in), 64'(w));
                n++;
            end else
                check("pe_in_v_gap", 64'(pe_in_v), 64'(0));
            cyc++;
        end
        din_overlay_v = 1'b0;
        start = 1'b0;
        pe_out_v = '0;
        check("load_words", 64'(n), 64'(TOT));
        check("run_din_ready", 64'({din_ready, busy}), 64'(2'b01));
        nm = mask_q.size();
        for (int j = 0; nm > 0 ? j < nm : (cap != '1 && j < 12); j++) begin
            m = nm > 0 ? mask_q[j] : PE_NUM'($urandom);
            pe_out_v = m;
            for (int k = 0; k < PE_NUM; k++) begin
                d = nominal ? W'(32'hA0 + k) : W'($urandom);
                pe_out[k*W +: W] = d;
                if (m[k] && !cap[k]) begin
                    exp_res[k] = d;
                    cap[k] = 1'b1;
                end
            end
            check("run_no_out", 64'(dout_overlay_v), 64'(0));
            tick();
            used++;
        end
        pe_out_v = '0;
        if (expect_to) begin
            for (int k = 0; k < PE_NUM; k++) if (!cap[k]) exp_res[k] = '0;
            while (used < RUN_CYCLES) begin
                check("to_wait_v", 64'(dout_overlay_v), 64'(0));
                check("to_wait_err", 64'(err), 64'(0));
                tick();
                used++;
            end
            check("to_err", 64'(err), 64'(1));
        end else begin
            check("all_cap", 64'(cap), 64'({PE_NUM{1'b1}}));
            check("run_settle", 64'(dout_overlay_v), 64'(0));
            tick();
        end
        cyc = 0;
        while (i < PE_NUM && cyc < 100) begin
            if (i == abort) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                dout_ready = 1'b0;
                check_reset_outputs("rst_mid_drain");
                mask_q.delete();
                return;
            end
            dout_ready = (i == hold && held < 5) ? 1'b0 : rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            check("dout_v", 64'(dout_overlay_v), 64'(1));
            check("dout", 64'(dout_overlay), 64'(exp_res[i]));
            tick();
            cyc++;
            if (dout_ready) i++;
            else if (i == hold) held++;
        end
        dout_ready = 1'b0;
        check("drain_count", 64'(i), 64'(PE_NUM));
        check("done_pulse", 64'({done, dout_overlay_v, busy}), 64'(3'b101));
        tick();
        check("done_end", 64'({done, busy}), 64'(0));
        check("err_after_job", 64'(err), 64'(expect_to));
        mask_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("idle");
        mask_q = '{4'hF};
        run_job(0, 1'b1, -1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        mask_q = '{4'h8, 4'h1, 4'h6};
        run_job(1, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        mask_q = '{4'hF};
        run_job(0, 1'b1, 1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        mask_q = '{4'h4, 4'h4, 4'h1, 4'h2, 4'h8};
        run_job(0, 1'b0, -1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        repeat (3) run_job(2, 1'b0, -1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        mask_q = '{4'hF};
        run_job(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_job(2, 1'b0, -1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
`ifdef PE_ARRAY_SCHED_TIMEOUT_EN
        mask_q = '{4'h1, 4'h2};
        run_job(0, 1'b1, -1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_job(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
